// File: rtl/coordenador_raio_busca_pkg.sv
// -----------------------------------------------------------------------------
// busca_pkg
// Shared types for the quadrant distance search: the coordinator FSM states,
// the "no candidate" distance marker and the candidate record exchanged with
// the search units.
// -----------------------------------------------------------------------------
package busca_pkg;

   // Width of radius, distance and coordinate fields in the shared record.
   localparam int DIST_W = 8;

   typedef enum logic [2:0] {
      IDLE,
      SCAN,
      SETTLE,
      DECIDE,
      PULSE,
      GUARD,
      FINAL,
      DONE
   } estado_t;

   // A unit reports this distance when it has no candidate cell.
   localparam logic [DIST_W-1:0] SEM_CANDIDATO = '1;

   typedef struct packed {
      logic [DIST_W-1:0] distancia;
      logic [DIST_W-1:0] x;
      logic [DIST_W-1:0] y;
   } candidato_t;

endpackage

// File: rtl/coordenador_raio_busca_seletor.sv
// -----------------------------------------------------------------------------
// seletor_candidato
// Combinational minimum selector over the candidates of all search units.
// Entries whose distance is SEM_CANDIDATO are ignored; on equal distances the
// lowest unit index wins.
//
// Ports:
//   candidatos  in   one candidate record per unit
//   valido      out  at least one unit holds a real candidate
//   indice      out  index of the winning unit (0 when valido is low)
//   melhor      out  winning record (distance SEM_CANDIDATO when valido is low)
// -----------------------------------------------------------------------------
module seletor_candidato
   import busca_pkg::*;
#(
   parameter int NumQuadrantes = 4,
   parameter int IDX_W         = 2
) (
   input  candidato_t [NumQuadrantes-1:0] candidatos,
   output logic                           valido,
   output logic       [IDX_W-1:0]         indice,
   output candidato_t                     melhor
);

   always_comb begin
      valido           = 1'b0;
      indice           = '0;
      melhor           = '0;
      melhor.distancia = SEM_CANDIDATO;
      // Strict less-than keeps the earlier index on a tie.
      for (int i = 0; i < NumQuadrantes; i++) begin
         if ((candidatos[i].distancia != SEM_CANDIDATO) &&
             (!valido || (candidatos[i].distancia < melhor.distancia))) begin
            valido = 1'b1;
            indice = IDX_W'(i);
            melhor = candidatos[i];
         end
      end
   end

endmodule

// File: rtl/coordenador_raio_busca.sv
// -----------------------------------------------------------------------------
// coordenador_raio_busca
// Initiator of the quadrant search handshake. Drives enable/raio/raioAtualizado
// into NumQuadrantes distance-search units, grows the radius one step at a time
// until some unit reports a candidate or every unit is finished (or the radius
// limit is reached), and presents the nearest candidate to the path planner.
//
// Optional build macro: COORDENADOR_WATCHDOG_EN
//   defined   -> a per-radius cycle counter aborts a SCAN that lasts
//                LimiteCiclos cycles, raising erro and finishing normally.
//   undefined -> no counter, erro is always 0, SCAN waits indefinitely.
//
// Ports:
//   clock, reset          clock (rising edge), asynchronous active-high reset
//   iniciar               start request, accepted only in IDLE
//   raioMaximo            largest radius to try (0 behaves as 1), sampled at start
//   acabouCalculoLocal    per-unit "radius scan done"
//   operacaoFinalizada    per-unit "search finished"
//   candidatoAtual        per-unit best distance (all ones = none)
//   coordenadaCandidatoX/Y per-unit candidate coordinates
//   enable                per-unit enable
//   raio                  current search radius
//   raioAtualizado        one-cycle pulse: new radius valid
//   ocupado               busy from accepted start until DONE
//   pronto                one-cycle pulse: result valid
//   encontrado            a candidate was found (held until next start)
//   melhorDistancia/X/Y   winning candidate (held until next start)
//   melhorQuadrante       index of the winning unit
//   erro                  watchdog abort flag
// -----------------------------------------------------------------------------
module coordenador_raio_busca
   import busca_pkg::*;
#(
   parameter  int TamanhoMalha     = 20,
   parameter  int tamanhoDistancia = DIST_W,
   parameter  int NumQuadrantes    = 4,
   parameter  int LimiteCiclos     = 4096,
   localparam int IDX_W            = (NumQuadrantes > 1) ? $clog2(NumQuadrantes) : 1
) (
   input  logic                                             clock,
   input  logic                                             reset,
   input  logic                                             iniciar,
   input  logic [tamanhoDistancia-1:0]                      raioMaximo,
   input  logic [NumQuadrantes-1:0]                         acabouCalculoLocal,
   input  logic [NumQuadrantes-1:0]                         operacaoFinalizada,
   input  logic [NumQuadrantes-1:0][tamanhoDistancia-1:0]   candidatoAtual,
   input  logic [NumQuadrantes-1:0][tamanhoDistancia-1:0]   coordenadaCandidatoX,
   input  logic [NumQuadrantes-1:0][tamanhoDistancia-1:0]   coordenadaCandidatoY,
   output logic [NumQuadrantes-1:0]                         enable,
   output logic [tamanhoDistancia-1:0]                      raio,
   output logic                                             raioAtualizado,
   output logic                                             ocupado,
   output logic                                             pronto,
   output logic                                             encontrado,
   output logic [tamanhoDistancia-1:0]                      melhorDistancia,
   output logic [tamanhoDistancia-1:0]                      melhorX,
   output logic [tamanhoDistancia-1:0]                      melhorY,
   output logic [IDX_W-1:0]                                 melhorQuadrante,
   output logic                                             erro
);

   // The candidate record is shared with the units, so its field width must
   // match the port width; the grid must also fit in the coordinate range.
   if ((tamanhoDistancia != DIST_W) || (TamanhoMalha < 1) ||
       (TamanhoMalha > (1 << tamanhoDistancia)) || (LimiteCiclos < 2)) begin : g_param_invalido
      $error("coordenador_raio_busca: inconsistent parameters");
   end

   estado_t                      estado;
   estado_t                      prox_estado;
   logic [NumQuadrantes-1:0]     mascara_fim;
   logic [NumQuadrantes-1:0]     mascara_decide;
   logic [tamanhoDistancia-1:0]  raio_max;
   logic                         scan_completo;
   logic                         estouro;

   candidato_t [NumQuadrantes-1:0] candidatos;
   logic                           sel_valido;
   logic       [IDX_W-1:0]         sel_indice;
   candidato_t                     sel_melhor;

   for (genvar q = 0; q < NumQuadrantes; q++) begin : g_cand
      assign candidatos[q].distancia = candidatoAtual[q];
      assign candidatos[q].x         = coordenadaCandidatoX[q];
      assign candidatos[q].y         = coordenadaCandidatoY[q];
   end

   seletor_candidato #(
      .NumQuadrantes (NumQuadrantes),
      .IDX_W         (IDX_W)
   ) u_seletor (
      .candidatos (candidatos),
      .valido     (sel_valido),
      .indice     (sel_indice),
      .melhor     (sel_melhor)
   );

   // Finished units no longer have to report a scan result.
   assign scan_completo  = &(acabouCalculoLocal | mascara_fim);
   assign mascara_decide = mascara_fim | operacaoFinalizada;

`ifdef COORDENADOR_WATCHDOG_EN
   localparam int CNT_W = $clog2(LimiteCiclos + 1);
   logic [CNT_W-1:0] ciclos;

   // Held at zero outside SCAN, so each radius starts counting from zero.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         ciclos <= '0;
      end else if (estado != SCAN) begin
         ciclos <= '0;
      end else begin
         ciclos <= ciclos + 1'b1;
      end
   end

   assign estouro = (estado == SCAN) && (ciclos == CNT_W'(LimiteCiclos - 1));
`else
   assign estouro = 1'b0;
`endif

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         estado <= IDLE;
      end else begin
         estado <= prox_estado;
      end
   end

   always_comb begin
      prox_estado = estado;
      case (estado)
         IDLE:    if (iniciar) prox_estado = SCAN;
         // A scan that completes wins over a watchdog expiring in the same cycle.
         SCAN:    if (scan_completo) prox_estado = SETTLE;
                  else if (estouro) prox_estado = FINAL;
         // operacaoFinalizada trails acabouCalculoLocal by one cycle.
         SETTLE:  prox_estado = DECIDE;
         DECIDE:  if (sel_valido || (&mascara_decide) || (raio == raio_max)) prox_estado = FINAL;
                  else prox_estado = PULSE;
         PULSE:   prox_estado = GUARD;
         // Gives the units one cycle to drop acabouCalculoLocal before SCAN looks again.
         GUARD:   prox_estado = SCAN;
         FINAL:   prox_estado = DONE;
         DONE:    prox_estado = IDLE;
         default: prox_estado = IDLE;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         enable          <= '0;
         raio            <= '0;
         raioAtualizado  <= 1'b0;
         ocupado         <= 1'b0;
         pronto          <= 1'b0;
         encontrado      <= 1'b0;
         melhorDistancia <= '0;
         melhorX         <= '0;
         melhorY         <= '0;
         melhorQuadrante <= '0;
         erro            <= 1'b0;
         mascara_fim     <= '0;
         raio_max        <= '0;
      end else begin
         case (estado)
            IDLE: begin
               if (iniciar) begin
                  raio            <= tamanhoDistancia'(1);
                  enable          <= '1;
                  mascara_fim     <= '0;
                  ocupado         <= 1'b1;
                  encontrado      <= 1'b0;
                  erro            <= 1'b0;
                  melhorDistancia <= '0;
                  melhorX         <= '0;
                  melhorY         <= '0;
                  melhorQuadrante <= '0;
                  raio_max        <= (raioMaximo == '0) ? tamanhoDistancia'(1) : raioMaximo;
               end
            end
            SCAN: begin
               if (!scan_completo && estouro) begin
                  erro       <= 1'b1;
                  encontrado <= 1'b0;
               end
            end
            DECIDE: begin
               mascara_fim <= mascara_decide;
               if (sel_valido) begin
                  encontrado      <= 1'b1;
                  melhorDistancia <= sel_melhor.distancia;
                  melhorX         <= sel_melhor.x;
                  melhorY         <= sel_melhor.y;
                  melhorQuadrante <= sel_indice;
               end
            end
            PULSE: begin
               // raio < raio_max here, so the increment cannot wrap.
               raio           <= raio + 1'b1;
               raioAtualizado <= 1'b1;
               enable         <= ~mascara_fim;
            end
            GUARD: begin
               raioAtualizado <= 1'b0;
            end
            FINAL: begin
               enable <= '0;
               pronto <= 1'b1;
            end
            DONE: begin
               pronto  <= 1'b0;
               ocupado <= 1'b0;
            end
            default: ;
         endcase
      end
   end

endmodule
